// File: rtl/bec_rr_sched.sv
// rtl/bec_rr_sched.sv - round-robin share of one byte-order converter between two requesters
module bec_rr_sched #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_data,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_data,
  input  logic [1:0]       req1_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int NB = DW / 8;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             acc;
  logic             grant_vld;
  logic             grant_id;
  logic             conv_en;
  logic [1:0]       conv_mode;
  logic [DW-1:0]    conv_din;
  logic [DW-1:0]    conv_dout;

  // Arbitration: prio breaks ties; a lone requester always wins.
  always_comb begin
    acc       = (!out_valid_q || out_ready) && !rst;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = prio_q;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
    req0_ready = acc && grant_vld && !grant_id;
    req1_ready = acc && grant_vld && grant_id;
    conv_en    = req0_ready || req1_ready;
    conv_din   = grant_id ? req1_data : req0_data;
    conv_mode  = grant_id ? req1_mode : req0_mode;
  end

  // Shared converter: swap32 reverses every byte, swap16 swaps bytes per half; idle output is zero.
  always_comb begin
    conv_dout = conv_din;
    case (conv_mode)
      2'b01: begin
        for (int b = 0; b < NB; b++) begin
          conv_dout[8*b +: 8] = conv_din[8*(NB-1-b) +: 8];
        end
      end
      2'b10: begin
        for (int h = 0; h < NB/2; h++) begin
          conv_dout[16*h +: 8]   = conv_din[16*h+8 +: 8];
          conv_dout[16*h+8 +: 8] = conv_din[16*h +: 8];
        end
      end
      default: conv_dout = conv_din;
    endcase
    if (!conv_en) begin
      conv_dout = '0;
    end
  end

  // Output register, pointer and saturating counters next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    prio_d      = prio_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (conv_en) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_dout;
      out_src_d   = grant_id;
      prio_d      = ~grant_id;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      if (out_src_q) begin
        if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_ONE;
      end else begin
        if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_ONE;
      end
    end
  end

  // State registers; reset drops any word in flight uncounted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      prio_q      <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      prio_q      <= prio_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_bec_rr_sched.sv
// tb/tb_bec_rr_sched.sv - directed vector bench for bec_rr_sched
module tb_bec_rr_sched;

  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [DW-1:0]    req0_data;
  logic [1:0]       req0_mode;
  logic             req1_valid, req1_ready;
  logic [DW-1:0]    req1_data;
  logic [1:0]       req1_mode;
  logic             out_valid, out_ready, out_src;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  bec_rr_sched #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_mode(req1_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0v;
    logic [31:0] r0d;
    logic [1:0]  r0m;
    logic        r1v;
    logic [31:0] r1d;
    logic [1:0]  r1m;
    logic        ordy;
    logic        e_r0rdy;
    logic        e_r1rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_src;
    logic [3:0]  e_c0;
    logic [3:0]  e_c1;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic r0v, input logic [31:0] r0d, input logic [1:0] r0m,
                              input logic r1v, input logic [31:0] r1d, input logic [1:0] r1m,
                              input logic ordy, input logic e0, input logic e1, input logic eov,
                              input logic [31:0] ed, input logic es, input logic [3:0] c0,
                              input logic [3:0] c1);
    vec_t v;
    v.r0v = r0v; v.r0d = r0d; v.r0m = r0m;
    v.r1v = r1v; v.r1d = r1d; v.r1m = r1m;
    v.ordy = ordy; v.e_r0rdy = e0; v.e_r1rdy = e1; v.e_ov = eov;
    v.e_data = ed; v.e_src = es; v.e_c0 = c0; v.e_c1 = c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0v, input logic [31:0] r0d, input logic [1:0] r0m,
                       input logic r1v, input logic [31:0] r1d, input logic [1:0] r1m,
                       input logic ordy);
    req0_valid = r0v; req0_data = r0d; req0_mode = r0m;
    req1_valid = r1v; req1_data = r1d; req1_mode = r1m;
    out_ready  = ordy;
  endtask

  int c0_model;

  initial begin
    // Table: pass/swap modes, fairness, backpressure with same-cycle reload.
    vt[0]  = mk(1, 32'h11223344, 2'b01, 0, 32'h0,        2'b00, 1, 1, 0, 1, 32'h44332211, 0, 0, 0);
    vt[1]  = mk(0, 32'h0,        2'b00, 1, 32'h11223344, 2'b10, 1, 0, 1, 1, 32'h22114433, 1, 1, 0);
    vt[2]  = mk(0, 32'h0,        2'b00, 1, 32'h11223344, 2'b00, 1, 0, 1, 1, 32'h11223344, 1, 1, 1);
    vt[3]  = mk(0, 32'h0,        2'b00, 1, 32'h11223344, 2'b11, 1, 0, 1, 1, 32'h11223344, 1, 1, 2);
    vt[4]  = mk(0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 1, 0, 0, 0, 32'h0,        0, 1, 3);
    vt[5]  = mk(1, 32'hAABBCCDD, 2'b01, 1, 32'h01020304, 2'b01, 1, 1, 0, 1, 32'hDDCCBBAA, 0, 1, 3);
    vt[6]  = mk(1, 32'hAABBCCDD, 2'b01, 1, 32'h01020304, 2'b01, 1, 0, 1, 1, 32'h04030201, 1, 2, 3);
    vt[7]  = mk(1, 32'hAABBCCDD, 2'b01, 1, 32'h01020304, 2'b01, 1, 1, 0, 1, 32'hDDCCBBAA, 0, 2, 4);
    vt[8]  = mk(1, 32'hAABBCCDD, 2'b01, 1, 32'h01020304, 2'b01, 1, 0, 1, 1, 32'h04030201, 1, 3, 4);
    vt[9]  = mk(0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 1, 0, 0, 0, 32'h0,        0, 3, 5);
    vt[10] = mk(1, 32'hCAFEBABE, 2'b00, 0, 32'h0,        2'b00, 0, 1, 0, 1, 32'hCAFEBABE, 0, 3, 5);
    vt[11] = mk(1, 32'h12345678, 2'b01, 1, 32'hA1B2C3D4, 2'b10, 0, 0, 0, 1, 32'hCAFEBABE, 0, 3, 5);
    vt[12] = mk(1, 32'h87654321, 2'b10, 1, 32'h0F0F0F0F, 2'b01, 0, 0, 0, 1, 32'hCAFEBABE, 0, 3, 5);
    vt[13] = mk(1, 32'h12345678, 2'b01, 1, 32'hA1B2C3D4, 2'b10, 0, 0, 0, 1, 32'hCAFEBABE, 0, 3, 5);
    vt[14] = mk(1, 32'h12345678, 2'b01, 1, 32'hA1B2C3D4, 2'b10, 1, 0, 1, 1, 32'hB2A1D4C3, 1, 4, 5);
    vt[15] = mk(0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 1, 0, 0, 0, 32'h0,        0, 4, 6);

    // Reset state.
    rst = 1'b1;
    drive(1, 32'h11223344, 2'b01, 1, 32'h11223344, 2'b01, 1);
    #1;
    chk("rst_r0rdy", {31'b0, req0_ready}, 32'h0);
    chk("rst_r1rdy", {31'b0, req1_ready}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ov",   {31'b0, out_valid}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_src",  {31'b0, out_src}, 32'h0);
    chk("rst_c0",   {28'b0, cnt0}, 32'h0);
    chk("rst_c1",   {28'b0, cnt1}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].r0v, vt[i].r0d, vt[i].r0m, vt[i].r1v, vt[i].r1d, vt[i].r1m, vt[i].ordy);
      #1;
      chk($sformatf("v%0d_r0rdy", i), {31'b0, req0_ready}, {31'b0, vt[i].e_r0rdy});
      chk($sformatf("v%0d_r1rdy", i), {31'b0, req1_ready}, {31'b0, vt[i].e_r1rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", i), {31'b0, out_valid}, {31'b0, vt[i].e_ov});
      if (vt[i].e_ov) begin
        chk($sformatf("v%0d_data", i), out_data, vt[i].e_data);
        chk($sformatf("v%0d_src", i), {31'b0, out_src}, {31'b0, vt[i].e_src});
      end
      chk($sformatf("v%0d_c0", i), {28'b0, cnt0}, {28'b0, vt[i].e_c0});
      chk($sformatf("v%0d_c1", i), {28'b0, cnt1}, {28'b0, vt[i].e_c1});
    end

    // Reset while a word is stalled: word dropped, counters and pointer cleared.
    drive(1, 32'h55667788, 2'b00, 0, 32'h0, 2'b00, 0);
    @(posedge clk); #1;
    chk("mid_ov_pre", {31'b0, out_valid}, 32'h1);
    rst = 1'b1;
    drive(1, 32'hAABBCCDD, 2'b01, 1, 32'h01020304, 2'b01, 0);
    #1;
    chk("mid_r0rdy_rst", {31'b0, req0_ready}, 32'h0);
    chk("mid_r1rdy_rst", {31'b0, req1_ready}, 32'h0);
    @(posedge clk); #1;
    chk("mid_ov",  {31'b0, out_valid}, 32'h0);
    chk("mid_c0",  {28'b0, cnt0}, 32'h0);
    chk("mid_c1",  {28'b0, cnt1}, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_first_r0rdy", {31'b0, req0_ready}, 32'h1);
    chk("mid_first_r1rdy", {31'b0, req1_ready}, 32'h0);
    @(posedge clk); #1;
    chk("mid_first_src",  {31'b0, out_src}, 32'h0);
    chk("mid_first_data", out_data, 32'hDDCCBBAA);

    // Saturation: stream requester 0 only; counter must stop at all-ones.
    drive(1, 32'hAABBCCDD, 2'b01, 0, 32'h0, 2'b00, 1);
    c0_model = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      c0_model = (c0_model < 15) ? c0_model + 1 : 15;
      chk($sformatf("sat_c0_%0d", k), {28'b0, cnt0}, c0_model);
    end
    chk("sat_final_c0", {28'b0, cnt0}, 32'hF);
    chk("sat_final_c1", {28'b0, cnt1}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
